// File: rtl/bcd_operand_entry_pkg.sv
// Shared definitions for the BCD operand entry block: digit limit, FSM
// encoding and the channel-to-bit-slice mapping used for the snapshot bus.
package bcd_operand_entry_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic {
    ENTRY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Lowest bit of channel k within a packed bus of DIGITS-wide BCD operands.
  function automatic int unsigned slice_offset(int unsigned k, int unsigned digits);
    return k * digits * 4;
  endfunction

endpackage

// File: rtl/bcd_digit_shifter.sv
// One operand channel: shift-accumulates BCD digits (most significant first)
// and keeps sticky non-BCD (err) and overflow (ovf) flags.
module bcd_digit_shifter
  import bcd_operand_entry_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [3:0]            digit,
  output logic [DIGITS*4-1:0]   value,
  output logic                  err,
  output logic                  ovf
);

  localparam int W  = DIGITS * 4;
  localparam int CW = $clog2(DIGITS + 1);

  logic [CW-1:0] count;
  logic          full;
  logic          bad;

  assign full = (count == CW'(DIGITS));
  assign bad  = (digit > BCD_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
      count <= '0;
      err   <= 1'b0;
      ovf   <= 1'b0;
    end else if (clr) begin
      value <= '0;
      count <= '0;
      err   <= 1'b0;
      ovf   <= 1'b0;
    end else if (en) begin
      if (bad)  err <= 1'b1;
      if (full) ovf <= 1'b1;
      if (!bad && !full) begin
        // Truncating the concatenation shifts left one digit; for DIGITS=1
        // it degenerates to a plain replace.
        value <= W'({value, digit});
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_operand_entry.sv
// Multi-channel BCD operand entry: routes digit strobes to per-channel
// shifters and hands a snapshot of all operands downstream on commit.
module bcd_operand_entry
  import bcd_operand_entry_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int CH     = 2,
  parameter int SELW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               digit,
  input  logic                     digit_stb,
  input  logic [SELW-1:0]          sel,
  input  logic                     clear,
  input  logic                     commit,
  output logic                     in_ready,
  output logic [CH-1:0]            err,
  output logic [CH-1:0]            ovf,
  output logic                     commit_rej,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH*DIGITS*4-1:0]   out_data
);

  state_t                   state, next_state;
  logic                     clr_all, load, rej, en_digit;
  logic [CH-1:0]            en;
  logic [CH*DIGITS*4-1:0]   work;

  for (genvar k = 0; k < CH; k++) begin : g_ch
    // A select value beyond CH-1 matches no channel and is thus ignored.
    assign en[k] = en_digit && (sel == SELW'(k));

    bcd_digit_shifter #(.DIGITS(DIGITS)) u_shifter (
      .clk   (clk),
      .rst   (rst),
      .en    (en[k]),
      .clr   (clr_all),
      .digit (digit),
      .value (work[slice_offset(k, DIGITS) +: DIGITS*4]),
      .err   (err[k]),
      .ovf   (ovf[k])
    );
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    clr_all    = 1'b0;
    load       = 1'b0;
    rej        = 1'b0;
    en_digit   = 1'b0;
    case (state)
      ENTRY: begin
        if (clear) begin
          clr_all = 1'b1;
        end else if (commit) begin
          if (|err) begin
            rej = 1'b1;
          end else begin
            load       = 1'b1;
            clr_all    = 1'b1;
            next_state = HOLD;
          end
        end else if (digit_stb) begin
          en_digit = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) next_state = ENTRY;
      end
      default: next_state = ENTRY;
    endcase
  end

  // NOTE: the snapshot register is reset because out_data must read zero
  // after reset; it is a plain register bank, not a RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ENTRY;
      commit_rej <= 1'b0;
      out_data   <= '0;
    end else begin
      state      <= next_state;
      commit_rej <= rej;
      if (load) out_data <= work;
    end
  end

  // Decoded straight from state so an asynchronous reset drops out_valid at once.
  assign in_ready  = (state == ENTRY);
  assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Directed bench for bcd_operand_entry (DIGITS=4, CH=2): expected snapshots
// are queued at commit time and checked by a monitor on each handshake.
module tb_bcd_operand_entry;

  localparam int DIGITS = 4;
  localparam int CH     = 2;
  localparam int SELW   = 1;
  localparam int DW     = CH * DIGITS * 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [3:0]      digit = '0;
  logic            digit_stb = 1'b0;
  logic [SELW-1:0] sel = '0;
  logic            clear = 1'b0;
  logic            commit = 1'b0;
  logic            in_ready;
  logic [CH-1:0]   err, ovf;
  logic            commit_rej;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  bcd_operand_entry #(.DIGITS(DIGITS), .CH(CH)) dut (
    .clk        (clk),
    .rst        (rst),
    .digit      (digit),
    .digit_stb  (digit_stb),
    .sel        (sel),
    .clear      (clear),
    .commit     (commit),
    .in_ready   (in_ready),
    .err        (err),
    .ovf        (ovf),
    .commit_rej (commit_rej),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a handshake completes on the next edge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL snapshot: got %h expected none queued", out_data);
      end else begin
        check("snapshot", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    digit_stb = 1'b0;
    clear     = 1'b0;
    commit    = 1'b0;
  endtask

  task automatic strobe(input int ch, input logic [3:0] d);
    sel       = SELW'(ch);
    digit     = d;
    digit_stb = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_valid", DW'(out_valid), '0);
    check("rst_data", out_data, '0);
    check("rst_flags", DW'({err, ovf, commit_rej}), '0);
    rst = 1'b1;
    tick();
    check("rst_ready", DW'(in_ready), DW'(1));

    // Basic entry and commit
    strobe(0, 4'd1); strobe(0, 4'd2); strobe(0, 4'd3);
    strobe(1, 4'd4); strobe(1, 4'd5);
    out_ready = 1'b1;
    exp_q.push_back(32'h0045_0123);
    commit = 1'b1; tick();
    check("t1_valid", DW'(out_valid), DW'(1));
    check("t1_err", DW'(err), '0);
    tick();
    check("t1_valid_drop", DW'(out_valid), '0);

    // Non-BCD digit and rejected commit
    strobe(1, 4'hC);
    check("t2_err", DW'(err), DW'(2'b10));
    commit = 1'b1; tick();
    check("t2_rej", DW'(commit_rej), DW'(1));
    check("t2_valid", DW'(out_valid), '0);
    tick();
    check("t2_rej_pulse", DW'(commit_rej), '0);
    check("t2_err_sticky", DW'(err), DW'(2'b10));
    clear = 1'b1; tick();
    check("t2_clear", DW'(err), '0);

    // Overflow does not block commit
    strobe(0, 4'd9); strobe(0, 4'd8); strobe(0, 4'd7); strobe(0, 4'd6); strobe(0, 4'd5);
    check("t3_ovf", DW'(ovf), DW'(2'b01));
    check("t3_err", DW'(err), '0);
    exp_q.push_back(32'h0000_9876);
    commit = 1'b1; tick();
    check("t3_valid", DW'(out_valid), DW'(1));
    tick();
    check("t3_ovf_zeroed", DW'(ovf), '0);

    // Backpressure: HOLD ignores requests
    out_ready = 1'b0;
    strobe(0, 4'd2); strobe(1, 4'd7);
    exp_q.push_back(32'h0007_0002);
    commit = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin
      sel = SELW'(i % 2); digit = 4'hF;
      digit_stb = 1'b1; clear = (i % 2 == 1); commit = (i == 2);
      tick();
      check("t4_ready", DW'(in_ready), '0);
      check("t4_data", out_data, 32'h0007_0002);
      check("t4_flags", DW'({err, ovf, commit_rej}), '0);
    end
    out_ready = 1'b1;
    tick();
    check("t4_back", DW'(in_ready), DW'(1));
    exp_q.push_back(32'h0000_0000);
    commit = 1'b1; tick();
    tick();

    // clear wins over commit and digit_stb
    strobe(0, 4'd3);
    clear = 1'b1; commit = 1'b1; digit_stb = 1'b1; sel = 1'b1; digit = 4'd6;
    tick();
    check("t5_rej", DW'(commit_rej), '0);
    check("t5_hold", DW'(out_valid), '0);
    check("t5_ready", DW'(in_ready), DW'(1));
    exp_q.push_back(32'h0000_0000);
    commit = 1'b1; tick();
    tick();

    // Asynchronous reset during HOLD
    out_ready = 1'b0;
    strobe(1, 4'd1);
    commit = 1'b1; tick();
    check("t6_hold", DW'(out_valid), DW'(1));
    #2 rst = 1'b0;
    #1;
    check("t6_async_valid", DW'(out_valid), '0);
    check("t6_async_data", out_data, '0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("t6_ready", DW'(in_ready), DW'(1));
    check("t6_outs", DW'({err, ovf, commit_rej, out_valid}), '0);
    check("t6_data", out_data, '0);

    check("queue_drained", DW'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
